fifo_rd_ctrl: RTL and testbench
===============================

// Module: fifo_rd_ctrl
// PURPOSE
//  Read-domain controller of the async MAC FIFO: owns the read pointer and consumes the write pointer
//  delivered by the two-flop write-to-read synchronizer. Issues reads to the dual-port RAM (1-cycle
//  read latency), presents first-word-fall-through data on a valid/ready stream, and publishes a gray
//  read pointer for the read-to-write synchronizer. Sits between the FIFO RAM and the downstream consumer.
// PARAMETERS
//  ADDR_WIDTH  4  RAM address bits; DEPTH = 2**ADDR_WIDTH; all pointers are ADDR_WIDTH+1 bits
//  DATA_WIDTH  8  word width
// PORTS
//  clk             in   1             read-domain clock
//  reset_n         in   1             async active-low reset
//  i_wr_ptr_gray   in   ADDR_WIDTH+1  write pointer, gray, already synchronized into clk
//  o_rd_ptr_gray   out  ADDR_WIDTH+1  registered gray read pointer, toward write domain
//  o_mem_ren       out  1             RAM read enable
//  o_mem_raddr     out  ADDR_WIDTH    RAM read address = rd_bin[ADDR_WIDTH-1:0]
//  i_mem_rdata     in   DATA_WIDTH    RAM data, valid the cycle after o_mem_ren
//  o_m_data        out  DATA_WIDTH    stream data
//  o_m_valid       out  1             stream valid
//  i_m_ready       in   1             stream ready
//  o_empty         out  1             = !o_m_valid
//  o_rd_count      out  ADDR_WIDTH+1  words available: (wr_bin_q - rd_bin) + inflight + stage_cnt
// BEHAVIOUR
//  - Reset: rd_bin=0, o_rd_ptr_gray=0, wr_bin_q=0, inflight=0, stage empty; o_m_valid=0, o_empty=1,
//    o_mem_ren=0, o_rd_count=0, o_m_data=0. Async assert clears everything immediately and discards
//    in-flight data; write side must be reset concurrently.
//  - wr_bin_q <= gray2bin(i_wr_ptr_gray) each cycle (one registration stage).
//  - Pointer-empty = (wr_bin_q == rd_bin). Full mod-2**(ADDR_WIDTH+1) arithmetic; extra MSB
//    disambiguates wrap. rd_bin wraps 2**(ADDR_WIDTH+1)-1 -> 0; the gray value changes by exactly one bit.
//  - Output stage is a 2-entry skid buffer. FSM S_EMPTY / S_ONE / S_TWO tracks stage_cnt.
//    - Push on inflight return.
//    - Pop on o_m_valid && i_m_ready.
//    - Push+pop in the same cycle holds the state.
//    - Push in S_TWO is illegal; the ren rule below prevents it.
//  - o_mem_ren (combinational from registered state) = !ptr_empty && (stage_cnt + inflight - pop) < 2.
//    On ren: rd_bin++, o_rd_ptr_gray <= bin2gray(rd_bin+1), inflight <= 1, else inflight <= 0.
//  - Latency: i_wr_ptr_gray change at edge N -> ren in cycle N+1 -> data in cycle N+2 -> o_m_valid in cycle N+3.
//    Sustained throughput is 1 word/cycle with ready held high.
//  - o_m_data/o_m_valid hold stable while valid && !ready. Order is strictly preserved; no drop or duplicate.
//  - Pointer leaves via o_rd_ptr_gray as soon as RAM is read, not when consumer pops; o_rd_count
//    counts staged and in-flight words, so it is <= DEPTH.
// CONFIGURATION
//  FIFO_ALMOST_EMPTY_EN defined:
//    - adds parameter ALMOST_EMPTY_THRESH (default 2) and output o_almost_empty (1 bit);
//    - o_almost_empty = (o_rd_count <= ALMOST_EMPTY_THRESH); reset value 1.
//  Not defined: parameter and port absent; no extra logic.
// STRUCTURE
//  - fifo_pkg:
//    - functions bin2gray/gray2bin, parameterized by width;
//    - enum typedef for S_EMPTY/S_ONE/S_TWO.
//  - The gray code functions are shared with the write controller.
//  - Sub-module fifo_skid_buf: 2-entry output stage + FSM, with ports push/data_in/pop/valid/data/cnt.
//    The parent keeps the pointer and ren logic.
// TESTING (ADDR_WIDTH=4, DATA_WIDTH=8)
//  1. Reset release -> o_empty=1, o_m_valid=0, o_mem_ren=0, o_rd_ptr_gray=5'b00000, o_rd_count=0.
//  2. i_wr_ptr_gray=5'b00001, RAM[0]=8'hA5, ready=1
//     -> ren with raddr 0 in cycle 1, valid with 8'hA5 in cycle 3, o_rd_ptr_gray=5'b00001, then o_empty=1.
//  3. wr ptr=8 (gray 5'b01100), ready=1 -> raddr 0..7 on consecutive cycles, 8 words back-to-back in order.
//  4. wr ptr=8, ready=0 -> exactly 2 reads issued, ren low, o_rd_count=8, data stable;
//     ready=1 -> remaining 6 fetched, words 0..7 in order, no gaps after refill.
//  5. Stream 40 words via write-side model -> rd pointer wraps 31->0 (gray 5'b10000->5'b00000), all data in order.
//  6. reset_n low mid-stream, no clock edge -> o_m_valid=0, o_mem_ren=0, pointer 0 immediately.
//     With FIFO_ALMOST_EMPTY_EN, THRESH=2: count 3->2 asserts o_almost_empty.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and gray-code helpers for the async FIFO read and write controllers.
package fifo_pkg;

  // Helpers work on a wide word; callers zero-extend in and truncate back to their pointer width.
  localparam int unsigned GRAY_MAX_W = 32;

  // Encoding equals the number of words held in the output stage.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry first-word-fall-through output stage; head entry drives the stream.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            cnt
);

  skid_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  pop_ok;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    pop_ok  = pop && (state_q != S_EMPTY);
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          head_d  = data_in;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (push && pop_ok) begin
          head_d = data_in;
        end else if (push) begin
          tail_d  = data_in;
          state_d = S_TWO;
        end else if (pop_ok) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // Parent never issues a read that could land here while full.
        if (pop_ok) begin
          head_d  = tail_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign valid = (state_q != S_EMPTY);
  assign data  = head_q;
  assign cnt   = 2'(state_q);

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: read pointer, RAM read issue, FWFT stream output.
// Optional FIFO_ALMOST_EMPTY_EN adds ALMOST_EMPTY_THRESH and o_almost_empty.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
`ifdef FIFO_ALMOST_EMPTY_EN
  ,
  parameter int unsigned ALMOST_EMPTY_THRESH = 2
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH:0]   i_wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   o_rd_ptr_gray,
  output logic                  o_mem_ren,
  output logic [ADDR_WIDTH-1:0] o_mem_raddr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_rd_count
`ifdef FIFO_ALMOST_EMPTY_EN
  ,
  output logic                  o_almost_empty
`endif
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] rd_bin_q, rd_bin_d;
  logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
  logic [PTR_W-1:0] wr_bin_q, wr_bin_d;
  logic             inflight_q, inflight_d;
  logic             ptr_empty;
  logic             pop;
  logic             ren;
  logic [1:0]       stage_cnt;
  logic [2:0]       occupancy;

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight_q),
    .data_in (i_mem_rdata),
    .pop     (pop),
    .valid   (o_m_valid),
    .data    (o_m_data),
    .cnt     (stage_cnt)
  );

  // Read issue: keep staged + in-flight words at most two after this cycle's pop.
  always_comb begin
    wr_bin_d   = PTR_W'(gray2bin(GRAY_MAX_W'(i_wr_ptr_gray)));
    ptr_empty  = (wr_bin_q == rd_bin_q);
    pop        = o_m_valid && i_m_ready;
    occupancy  = 3'(stage_cnt) + 3'(inflight_q) - 3'(pop);
    ren        = !ptr_empty && (occupancy < 3'd2);
    rd_bin_d   = rd_bin_q;
    rd_gray_d  = rd_gray_q;
    inflight_d = ren;
    if (ren) begin
      rd_bin_d  = rd_bin_q + PTR_W'(1);
      rd_gray_d = PTR_W'(bin2gray(GRAY_MAX_W'(rd_bin_d)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_bin_q   <= '0;
      rd_gray_q  <= '0;
      wr_bin_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      rd_bin_q   <= rd_bin_d;
      rd_gray_q  <= rd_gray_d;
      wr_bin_q   <= wr_bin_d;
      inflight_q <= inflight_d;
    end
  end

  assign o_rd_ptr_gray = rd_gray_q;
  assign o_mem_ren     = ren;
  assign o_mem_raddr   = rd_bin_q[ADDR_WIDTH-1:0];
  assign o_empty       = !o_m_valid;
  // Words unread in RAM plus those already fetched but not yet consumed.
  assign o_rd_count    = (wr_bin_q - rd_bin_q) + PTR_W'(inflight_q) + PTR_W'(stage_cnt);

`ifdef FIFO_ALMOST_EMPTY_EN
  assign o_almost_empty = (32'(o_rd_count) <= ALMOST_EMPTY_THRESH);
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: directed vectors, RAM and write-side models, decoupled monitor.
module tb_fifo_rd_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW:0]   i_wr_ptr_gray;
  logic [AW:0]   o_rd_ptr_gray;
  logic          o_mem_ren;
  logic [AW-1:0] o_mem_raddr;
  logic [DW-1:0] i_mem_rdata;
  logic [DW-1:0] o_m_data;
  logic          o_m_valid;
  logic          i_m_ready;
  logic          o_empty;
  logic [AW:0]   o_rd_count;
`ifdef FIFO_ALMOST_EMPTY_EN
  logic          o_almost_empty;
`endif

  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_q [$];
  logic [AW:0]   wr_bin;
  int            n_vec = 0;
  int            n_err = 0;
  logic          hold_q = 1'b0;
  logic [DW-1:0] hold_data = '0;

  fifo_rd_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
`ifdef FIFO_ALMOST_EMPTY_EN
    ,
    .ALMOST_EMPTY_THRESH (2)
`endif
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_wr_ptr_gray (i_wr_ptr_gray),
    .o_rd_ptr_gray (o_rd_ptr_gray),
    .o_mem_ren     (o_mem_ren),
    .o_mem_raddr   (o_mem_raddr),
    .i_mem_rdata   (i_mem_rdata),
    .o_m_data      (o_m_data),
    .o_m_valid     (o_m_valid),
    .i_m_ready     (i_m_ready),
    .o_empty       (o_empty),
    .o_rd_count    (o_rd_count)
`ifdef FIFO_ALMOST_EMPTY_EN
    ,
    .o_almost_empty (o_almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // One-cycle-latency RAM model.
  always @(posedge clk) begin
    if (o_mem_ren) i_mem_rdata <= mem[o_mem_raddr];
  end

  function automatic logic [AW:0] b2g(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word and checks stall stability.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!reset_n) begin
      hold_q <= 1'b0;
    end else begin
      if (hold_q) begin
        check("stall_valid", 32'(o_m_valid), 32'd1);
        check("stall_data", 32'(o_m_data), 32'(hold_data));
      end
      if (o_m_valid && i_m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", o_m_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", 32'(o_m_data), 32'(e));
        end
      end
      hold_q    <= o_m_valid && !i_m_ready;
      hold_data <= o_m_data;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next();
    reset_n       = 1'b0;
    i_wr_ptr_gray = '0;
    i_m_ready     = 1'b0;
    wr_bin        = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Loads n words starting at base and publishes the write pointer in one step.
  task automatic load_words(input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      mem[k] = base + DW'(k);
      exp_q.push_back(base + DW'(k));
    end
    wr_bin        = (AW+1)'(n);
    i_wr_ptr_gray = b2g(wr_bin);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nren;
    int          sent;
    int          cyc;
    logic [AW:0] prev_g;
    logic        wrapped;

    reset_n       = 1'b0;
    i_wr_ptr_gray = '0;
    i_m_ready     = 1'b0;
    wr_bin        = '0;

    // Reset state.
    do_reset();
    @(negedge clk);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_valid", 32'(o_m_valid), 32'd0);
    check("rst_ren", 32'(o_mem_ren), 32'd0);
    check("rst_gray", 32'(o_rd_ptr_gray), 32'd0);
    check("rst_count", 32'(o_rd_count), 32'd0);
    check("rst_data", 32'(o_m_data), 32'd0);

    // Single word: latency from write-pointer change to valid.
    next();
    mem[0] = 8'hA5;
    exp_q.push_back(8'hA5);
    i_m_ready     = 1'b1;
    wr_bin        = 5'd1;
    i_wr_ptr_gray = b2g(wr_bin);
    @(negedge clk); check("t2_ren_c0", 32'(o_mem_ren), 32'd0);
    @(negedge clk); check("t2_ren_c1", 32'(o_mem_ren), 32'd1);
    check("t2_raddr", 32'(o_mem_raddr), 32'd0);
    @(negedge clk); check("t2_valid_c2", 32'(o_m_valid), 32'd0);
    check("t2_gray", 32'(o_rd_ptr_gray), 32'b00001);
    @(negedge clk); check("t2_valid_c3", 32'(o_m_valid), 32'd1);
    @(negedge clk); check("t2_empty_c4", 32'(o_empty), 32'd1);
    drain(5);

    // Eight words, ready high: consecutive reads, back-to-back output.
    do_reset();
    next();
    i_m_ready = 1'b1;
    load_words(8, 8'h10);
    check("t3_gray_in", 32'(i_wr_ptr_gray), 32'b01100);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) begin
        check("t3_ren", 32'(o_mem_ren), 32'd1);
        check("t3_raddr", 32'(o_mem_raddr), 32'(k));
      end
      if (k >= 2) check("t3_valid", 32'(o_m_valid), 32'd1);
    end
    drain(10);

    // Eight words, ready low: only two reads, then refill without gaps.
    do_reset();
    next();
    load_words(8, 8'h40);
    nren = 0;
    repeat (8) begin
      @(negedge clk);
      nren += int'(o_mem_ren);
    end
    check("t4_reads", 32'(nren), 32'd2);
    check("t4_ren_low", 32'(o_mem_ren), 32'd0);
    check("t4_count", 32'(o_rd_count), 32'd8);
    check("t4_head", 32'(o_m_data), 32'h40);
    next();
    i_m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t4_no_gap", 32'(o_m_valid), 32'd1);
    end
    @(negedge clk);
    check("t4_empty", 32'(o_empty), 32'd1);
    drain(5);

    // Forty words through a write-side model with random ready; pointer must wrap.
    do_reset();
    sent    = 0;
    cyc     = 0;
    prev_g  = '0;
    wrapped = 1'b0;
    while ((sent < 40 || exp_q.size() != 0) && cyc < 2000) begin
      next();
      cyc++;
      i_m_ready = ($urandom_range(3) != 0);
      if (sent < 40 && (5'(wr_bin - g2b(o_rd_ptr_gray)) < 5'd16)) begin
        mem[wr_bin[AW-1:0]] = DW'(sent * 7 + 3);
        exp_q.push_back(DW'(sent * 7 + 3));
        wr_bin        = wr_bin + 5'd1;
        i_wr_ptr_gray = b2g(wr_bin);
        sent++;
      end
      @(negedge clk);
      if (o_rd_ptr_gray != prev_g) begin
        check("t5_gray_step", 32'($countones(o_rd_ptr_gray ^ prev_g)), 32'd1);
        if (prev_g == 5'b10000 && o_rd_ptr_gray == 5'b00000) wrapped = 1'b1;
        prev_g = o_rd_ptr_gray;
      end
    end
    check("t5_sent", 32'(sent), 32'd40);
    check("t5_wrap", 32'(wrapped), 32'd1);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_ALMOST_EMPTY_EN
    // Almost-empty asserts as the count drops from 3 to 2.
    do_reset();
    next();
    load_words(3, 8'h70);
    repeat (6) @(negedge clk);
    check("ae_count3", 32'(o_rd_count), 32'd3);
    check("ae_low", 32'(o_almost_empty), 32'd0);
    next();
    i_m_ready = 1'b1;
    next();
    i_m_ready = 1'b0;
    @(negedge clk);
    check("ae_count2", 32'(o_rd_count), 32'd2);
    check("ae_high", 32'(o_almost_empty), 32'd1);
    i_m_ready = 1'b1;
    drain(10);
`endif

    // Asynchronous reset mid-stream, between clock edges.
    do_reset();
    next();
    i_m_ready = 1'b1;
    load_words(8, 8'h90);
    repeat (4) @(negedge clk);
    check("t6_pre_valid", 32'(o_m_valid), 32'd1);
    check("t6_pre_ren", 32'(o_mem_ren), 32'd1);
    #2;
    reset_n       = 1'b0;
    i_wr_ptr_gray = '0;
    wr_bin        = '0;
    exp_q.delete();
    #1;
    check("t6_valid", 32'(o_m_valid), 32'd0);
    check("t6_ren", 32'(o_mem_ren), 32'd0);
    check("t6_gray", 32'(o_rd_ptr_gray), 32'd0);
    check("t6_count", 32'(o_rd_count), 32'd0);
    check("t6_empty", 32'(o_empty), 32'd1);
    next();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_stays_empty", 32'(o_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
